// File: rtl/vga_lockstep_monitor.sv
// rtl/vga_lockstep_monitor.sv - lockstep VGA mismatch fault manager with AHB-Lite register port
module vga_lockstep_monitor #(
    parameter int THRESH = 2,
    parameter int CNTW   = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        MISMATCH,
    input  logic [7:0]  RGB_IN,
    output logic [7:0]  RGB_OUT,
    output logic        FAULT,
    output logic        IRQ,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [3:0]  HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_FLT  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = 1;

    state_t            state_q;
    logic [7:0]        run_q;
    logic              fault_q;
    logic [31:0]       first_q;
    logic [31:0]       timer_q;
    logic [CNTW-1:0]   count_q, count_d;
    logic [1:0]        ctrl_q;
    logic [7:0]        rgb_q;
    logic              dp_valid_q, dp_write_q;
    logic [1:0]        dp_addr_q;

    logic              accept, wr_en, clr, cnt_clr, enter_flt;
    logic [8:0]        run_inc;
    logic              unused_bits;

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign wr_en     = dp_valid_q & dp_write_q;
    assign clr       = wr_en & (dp_addr_q == 2'd3) & HWDATA[2];
    assign cnt_clr   = wr_en & (dp_addr_q == 2'd1);
    assign run_inc   = {1'b0, run_q} + 9'd1;
    assign enter_flt = MISMATCH &
                       (((state_q == ST_IDLE) && (THRESH == 1)) ||
                        ((state_q == ST_PEND) && (run_inc >= 9'(THRESH))));
    assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:3]};

    assign FAULT     = fault_q;
    assign IRQ       = fault_q & ctrl_q[0];
    assign RGB_OUT   = rgb_q;
    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
        end else begin
            dp_valid_q <= accept;
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[3:2];
        end
    end

    // A clear that lands on the edge entering FLT wins: the run restarts from zero.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            run_q   <= 8'd0;
            fault_q <= 1'b0;
            first_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PEND: begin
                    if (!MISMATCH) begin
                        state_q <= ST_IDLE;
                        run_q   <= 8'd0;
                    end else if (enter_flt) begin
                        if (clr) begin
                            state_q <= ST_PEND;
                            run_q   <= 8'd0;
                        end else begin
                            state_q <= ST_FLT;
                            fault_q <= 1'b1;
                            first_q <= timer_q;
                        end
                    end else begin
                        state_q <= ST_PEND;
                        run_q   <= run_inc[7:0];
                    end
                end
                ST_FLT: begin
                    if (clr) begin
                        state_q <= ST_IDLE;
                        run_q   <= 8'd0;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 8'd0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = MISMATCH ? CNT_ONE : '0;
        end else if (MISMATCH && (count_q != {CNTW{1'b1}})) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            count_q <= '0;
            timer_q <= 32'd0;
            ctrl_q  <= 2'd0;
            rgb_q   <= 8'd0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_q + 32'd1;
            if (wr_en && (dp_addr_q == 2'd3)) begin
                ctrl_q <= HWDATA[1:0];
            end
            rgb_q <= (fault_q & ctrl_q[1]) ? 8'd0 : RGB_IN;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                2'd0: HRDATA = {29'd0, state_q, fault_q};
                2'd1: HRDATA[CNTW-1:0] = count_q;
                2'd2: HRDATA = first_q;
                default: HRDATA = {30'd0, ctrl_q};
            endcase
        end
    end

endmodule

// File: tb/tb_vga_lockstep_monitor.sv
// tb/tb_vga_lockstep_monitor.sv - randomized and directed bench for vga_lockstep_monitor
module tb_vga_lockstep_monitor;

    localparam int THRESH  = 2;
    localparam int CNTW    = 8;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        MISMATCH = 1'b0;
    logic [7:0]  RGB_IN = 8'd0;
    logic [7:0]  RGB_OUT;
    logic        FAULT, IRQ;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
    logic [1:0]  HTRANS = 2'b00;
    logic [3:0]  HADDR = 4'd0;
    logic [31:0] HWDATA = 32'd0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    vga_lockstep_monitor #(.THRESH(THRESH), .CNTW(CNTW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .MISMATCH(MISMATCH),
        .RGB_IN(RGB_IN), .RGB_OUT(RGB_OUT), .FAULT(FAULT), .IRQ(IRQ),
        .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY), .HTRANS(HTRANS),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: fault = THRESH consecutive mismatches since the last quiet cycle or clear
    logic [31:0] m_timer, m_first;
    bit          m_fault, m_pend, m_irqen, m_blanken;
    int          m_run, m_count;
    logic [7:0]  m_rgb;
    bit          m_dpv, m_dpw;
    logic [1:0]  m_dpa;

    task automatic model_reset();
        m_timer = 0; m_first = 0; m_fault = 0; m_pend = 0; m_irqen = 0; m_blanken = 0;
        m_run = 0; m_count = 0; m_rgb = 0; m_dpv = 0; m_dpw = 0; m_dpa = 0;
    endtask

    function automatic logic [31:0] model_rdata();
        logic [1:0] st;
        st = m_fault ? 2'd2 : (m_pend ? 2'd1 : 2'd0);
        if (!(m_dpv && !m_dpw)) return 32'd0;
        case (m_dpa)
            2'd0: return {29'd0, st, m_fault};
            2'd1: return 32'(m_count);
            2'd2: return m_first;
            default: return {30'd0, m_blanken, m_irqen};
        endcase
    endfunction

    task automatic model_edge();
        bit wr, clr, cclr;
        wr   = m_dpv && m_dpw;
        clr  = wr && (m_dpa == 2'd3) && HWDATA[2];
        cclr = wr && (m_dpa == 2'd1);
        m_rgb = (m_fault && m_blanken) ? 8'd0 : RGB_IN;
        if (m_fault) begin
            if (clr) begin m_fault = 0; m_pend = 0; m_run = 0; end
        end else if (!MISMATCH) begin
            m_run = 0; m_pend = 0;
        end else begin
            m_run++;
            m_pend = 1;
            if (m_run >= THRESH) begin
                if (clr) m_run = 0;
                else begin m_fault = 1; m_pend = 0; m_first = m_timer; end
            end
        end
        if (cclr) m_count = MISMATCH ? 1 : 0;
        else if (MISMATCH && m_count < CNT_MAX) m_count++;
        if (wr && m_dpa == 2'd3) begin m_irqen = HWDATA[0]; m_blanken = HWDATA[1]; end
        m_timer = m_timer + 32'd1;
        m_dpv = HSEL && HTRANS[1] && HREADY;
        m_dpw = HWRITE;
        m_dpa = HADDR[3:2];
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
        check_eq("fault", {31'd0, FAULT}, {31'd0, m_fault});
        check_eq("irq", {31'd0, IRQ}, {31'd0, m_fault & m_irqen});
        check_eq("rgb_out", {24'd0, RGB_OUT}, {24'd0, m_rgb});
        check_eq("hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check_eq("hrdata", HRDATA, model_rdata());
    endtask

    task automatic idle_bus();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 4'd0;
    endtask

    task automatic addr_phase(input bit wr, input logic [3:0] a);
        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
    endtask

    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        addr_phase(1, a);
        step();
        idle_bus();
        HWDATA = d;
        step();
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        addr_phase(0, a);
        step();
        idle_bus();
        d = HRDATA;
    endtask

    task automatic apply_reset();
        idle_bus();
        HRESET = 1;
        model_reset();
        #1;
        check_eq("rst_fault", {31'd0, FAULT}, 32'd0);
        check_eq("rst_irq", {31'd0, IRQ}, 32'd0);
        check_eq("rst_rgb", {24'd0, RGB_OUT}, 32'd0);
        check_eq("rst_hrdata", HRDATA, 32'd0);
        check_eq("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        @(posedge HCLK);
        #1;
        HRESET = 0;
    endtask

    logic [31:0] d;

    initial begin
        #1;
        apply_reset();

        // isolated single-cycle pulses never reach the threshold
        addr_phase(0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            MISMATCH = 1;
            step();
            check_eq("status_pend", {30'd0, HRDATA[2:1]}, 32'd1);
            MISMATCH = 0;
            step();
            check_eq("status_idle", {30'd0, HRDATA[2:1]}, 32'd0);
            step();
            step();
        end
        ahb_read(4'h4, d);
        check_eq("count_pulses", d, 32'd10);
        check_eq("no_fault_pulses", {31'd0, FAULT}, 32'd0);

        // fault with timestamp
        apply_reset();
        for (int i = 0; i < 200 && m_timer != 32'd100; i++) step();
        MISMATCH = 1;
        step();
        step();
        MISMATCH = 0;
        check_eq("fault_set", {31'd0, FAULT}, 32'd1);
        check_eq("irq_masked", {31'd0, IRQ}, 32'd0);
        ahb_read(4'h8, d);
        check_eq("first_ts", d, 32'd101);
        ahb_write(4'hC, 32'h1);
        check_eq("irq_enabled", {31'd0, IRQ}, 32'd1);

        // blanking
        RGB_IN = 8'hE3;
        ahb_write(4'hC, 32'h7);
        step();
        check_eq("rgb_pass", {24'd0, RGB_OUT}, 32'hE3);
        MISMATCH = 1;
        step();
        step();
        MISMATCH = 0;
        check_eq("fault_blank", {31'd0, FAULT}, 32'd1);
        step();
        check_eq("rgb_blanked", {24'd0, RGB_OUT}, 32'h0);
        ahb_write(4'hC, 32'h7);
        check_eq("clr_fault", {31'd0, FAULT}, 32'd0);
        check_eq("rgb_still_blank", {24'd0, RGB_OUT}, 32'h0);
        step();
        check_eq("rgb_restored", {24'd0, RGB_OUT}, 32'hE3);

        // counter saturation and clear-with-increment
        ahb_write(4'hC, 32'h0);
        MISMATCH = 1;
        repeat (300) step();
        ahb_read(4'h4, d);
        check_eq("count_sat", d, 32'd255);
        ahb_write(4'h4, 32'h0);
        MISMATCH = 0;
        ahb_read(4'h4, d);
        check_eq("count_clr_inc", d, 32'd1);
        ahb_write(4'hC, 32'h4);
        step();
        step();

        // clear colliding with the threshold edge
        MISMATCH = 1;
        addr_phase(1, 4'hC);
        step();
        idle_bus();
        HWDATA = 32'h4;
        step();
        check_eq("clr_wins", {31'd0, FAULT}, 32'd0);
        step();
        check_eq("rearm_wait", {31'd0, FAULT}, 32'd0);
        step();
        check_eq("rearm_fault", {31'd0, FAULT}, 32'd1);
        MISMATCH = 0;

        // asynchronous reset while faulted
        ahb_write(4'hC, 32'h7);
        ahb_write(4'h4, 32'h0);
        MISMATCH = 1;
        repeat (37) step();
        MISMATCH = 0;
        addr_phase(0, 4'h4);
        step();
        check_eq("count37", HRDATA, 32'd37);
        check_eq("irq_before_rst", {31'd0, IRQ}, 32'd1);
        #2;
        apply_reset();
        ahb_read(4'h4, d);
        check_eq("rst_count", d, 32'd0);
        ahb_read(4'h8, d);
        check_eq("rst_first", d, 32'd0);
        ahb_read(4'hC, d);
        check_eq("rst_ctrl", d, 32'd0);

        // randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            MISMATCH = ($urandom_range(0, 9) < 4);
            RGB_IN = 8'($urandom);
            if ($urandom_range(0, 3) == 0) idle_bus();
            else addr_phase(1'($urandom), 4'($urandom));
            HWDATA = ($urandom & 32'hFFFF_FFFB) | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
